// File: rtl/mips_ifetch.sv
// Instruction fetch: owns the PC, drives a 1-cycle synchronous ROM, registers inst/pc/valid for decode.
// Stall freezes all fetch state; redirect flushes (target valid 3 cycles later). IFETCH_PERF_CNT_EN adds fetch/stall counters.
module mips_ifetch #(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       inst_code,
    output logic [31:0]       inst_pc,
    output logic              inst_valid,
    output logic [31:0]       pc_plus4
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    logic [31:0] pc_q, pc_d;
    logic        req_v_q, req_v_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] inst_code_q, inst_code_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;

    // While stalled, keep re-reading the pending word so imem_data still matches req_pc.
    assign imem_addr  = (stall && req_v_q) ? req_pc_q[ADDR_W+1:2] : pc_q[ADDR_W+1:2];
    assign inst_code  = inst_code_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign pc_plus4   = inst_pc_q + 32'd4;

    always_comb begin
        pc_d         = pc_q;
        req_v_d      = req_v_q;
        req_pc_d     = req_pc_q;
        inst_code_d  = inst_code_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        if (redirect) begin
            pc_d         = redirect_pc & 32'hFFFF_FFFC;
            req_v_d      = 1'b0;
            inst_valid_d = 1'b0;
        end else if (!stall) begin
            req_v_d  = 1'b1;
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            if (req_v_q) begin
                inst_code_d  = imem_data;
                inst_pc_d    = req_pc_q;
                inst_valid_d = 1'b1;
            end else begin
                inst_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            req_v_q      <= 1'b0;
            req_pc_q     <= 32'h0;
            inst_code_q  <= 32'h0;
            inst_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            req_v_q      <= req_v_d;
            req_pc_q     <= req_pc_d;
            inst_code_q  <= inst_code_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;

    // A fetch counts when decode actually takes the instruction.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (inst_valid_q && !stall) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (stall && !redirect) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: doc/mips_ifetch.md
Name: mips_ifetch

Overview:
- Parametrised instruction-fetch unit for the MIPS core.
- Owns the program counter and drives a synchronous-read instruction ROM (1-cycle read latency).
- Presents a registered instruction/PC pair with a valid flag to decode.
- Adds stall hold, branch/jump redirect with flush, configurable ROM depth and reset vector, and wrap-around.

Parameters:
- ADDR_W, 6, word-index width of the instruction ROM (depth = 2^ADDR_W words).
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decode cannot accept; hold all fetch state.
- redirect  in  1  branch/jump taken; flush and restart at redirect_pc.
- redirect_pc  in  32  target byte address; bits [1:0] ignored (forced to 0).
- imem_addr  out  ADDR_W  ROM word address, combinational.
- imem_data  in  32  ROM read data, valid one cycle after imem_addr.
- inst_code  out  32  registered instruction word.
- inst_pc  out  32  byte address of inst_code.
- inst_valid  out  1  inst_code/inst_pc hold a live instruction.
- pc_plus4  out  32  inst_pc + 4, combinational, for link/branch base.

Behaviour:
- Internal state:
  - pc: next address to issue.
  - req_v/req_pc: request issued last cycle, data on imem_data this cycle.
  - Output registers: inst_code, inst_pc, inst_valid.
- imem_addr:
  - = req_pc[ADDR_W+1:2] when stall=1 and req_v=1, so the ROM re-reads the pending word and imem_data stays coherent across the stall.
  - Otherwise = pc[ADDR_W+1:2].
- Reset (rst=1 at clock edge):
  - pc=RESET_PC, req_v=0, req_pc=0.
  - inst_code=0, inst_pc=0, inst_valid=0.
  - rst has priority over redirect and stall.
- Normal cycle (rst=0, redirect=0, stall=0):
  - req_v<=1, req_pc<=pc, pc<=pc+4.
  - If req_v: inst_code<=imem_data, inst_pc<=req_pc, inst_valid<=1.
  - Else inst_valid<=0; inst_code and inst_pc hold.
- Stall (redirect=0, stall=1): pc, req_v, req_pc and output registers all hold. No instruction is lost or duplicated.
- Redirect (redirect=1, rst=0):
  - pc<={redirect_pc[31:2],2'b00}, req_v<=0, inst_valid<=0.
  - Overrides a simultaneous stall; the in-flight request is discarded.
- Latency:
  - First valid after reset release: rst low in cycle R → imem_addr=RESET_PC index in R → inst_valid=1 with inst_pc=RESET_PC in cycle R+2.
  - Redirect: redirect sampled at end of cycle N → inst_valid=0 in N+1 and N+2 → target valid in N+3.
  - Throughput without stall: one instruction per cycle.
- Width and wrap:
  - pc arithmetic is 32-bit modulo 2^32.
  - ROM index wraps naturally at 2^ADDR_W words; inst_pc keeps full 32-bit value (e.g. ADDR_W=6, pc=0x100 reads word 0 but inst_pc=0x100).
- Redirect back-to-back every cycle: inst_valid stays 0; pc follows the latest redirect_pc.
- Redirect to the current inst_pc is legal and refetches it.

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- With it defined:
  - Adds output port fetch_cnt[31:0] and output port stall_cnt[31:0], both reset to 0 by rst.
  - fetch_cnt increments on every cycle with inst_valid=1 and stall=0 (instruction consumed by decode).
  - stall_cnt increments on every cycle with stall=1 and redirect=0.
  - Both counters wrap at 2^32; redirect does not clear them.
- Without it: neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- Reset/sequential, ADDR_W=6, ROM word i = 0x1000_0000+i: release rst → cycle R+2 inst_valid=1, inst_pc=0x0, inst_code=0x1000_0000; following cycles give inst_pc 0x4, 0x8 with codes 0x1000_0001, 0x1000_0002.
- Stall: assert stall for 3 cycles while inst_pc=0x8 → outputs hold 0x8/0x1000_0002 for all 3 cycles; after release, next is 0xC/0x1000_0003, no skip or duplicate.
- Redirect: redirect=1, redirect_pc=0x23 while streaming → two cycles inst_valid=0, then inst_pc=0x20, inst_code=0x1000_0008, then 0x24.
- Redirect+stall simultaneous with redirect_pc=0x40 → redirect wins; inst_pc=0x40 valid 3 cycles later even if stall is held low afterwards.
- Wrap: RESET_PC=0xF8 → inst_pc sequence 0xF8, 0xFC, 0x100 with codes 0x1000_003E, 0x1000_003F, 0x1000_0000.
- IFETCH_PERF_CNT_EN: 10 consumed instructions plus 4 stall cycles → fetch_cnt=10, stall_cnt=4; assert rst mid-run → both read 0 next cycle.
